// File: rtl/mmio_led_pwm_if.sv
// rtl/mmio_led_pwm_if.sv - data-memory port bundle between the core and the LED peripheral
interface mmio_led_pwm_if;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        sel;

    modport master (output we, output a, output wd, input rd, input sel);
    modport slave  (input we, input a, input wd, output rd, output sel);
endinterface

// File: rtl/mmio_led_pwm.sv
// rtl/mmio_led_pwm.sv - memory-mapped LED block with static, PWM and blink-gated channels
module mmio_led_pwm #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          ADDR_W     = 8,
    parameter int          N_LED      = 8,
    parameter int          PWM_BITS   = 8,
    parameter int          PRESCALE_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    mmio_led_pwm_if.slave      bus,
    output logic [N_LED-1:0]   led
);
    localparam int WW = ADDR_W - 2;
    localparam logic [WW-1:0] W_CTRL     = WW'(0);
    localparam logic [WW-1:0] W_LED_OUT  = WW'(1);
    localparam logic [WW-1:0] W_PRESCALE = WW'(2);
    localparam logic [WW-1:0] W_STATUS   = WW'(3);

    logic [2:0]            ctrl;
    logic [N_LED-1:0]      led_out;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] presc_cnt;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic                  blink_phase;
    logic [PWM_BITS:0]     duty [N_LED];

    logic [WW-1:0]    word;
    logic             wr;
    logic             tick;
    logic             clear;
    logic [N_LED-1:0] raw;
    logic [31:0]      rd_mux;
    logic             unused_bits;

    // Byte lanes are ignored: the window is word-addressed
    assign word        = bus.a[ADDR_W-1:2];
    assign bus.sel     = (bus.a[31:ADDR_W] == BASE_ADDR[31:ADDR_W]);
    assign wr          = bus.we && bus.sel;
    assign unused_bits = ^{bus.a[1:0], bus.wd};

    assign tick  = ctrl[0] && (presc_cnt == prescale);
    assign clear = wr && (((word == W_CTRL) && !bus.wd[0]) || (word == W_PRESCALE));

    always_comb begin
        for (int i = 0; i < N_LED; i++) begin
            raw[i] = ctrl[1] ? ({1'b0, pwm_cnt} < duty[i]) : led_out[i];
        end
    end

    always_comb begin
        rd_mux = '0;
        if (bus.sel) begin
            case (word)
                W_CTRL:     rd_mux = 32'(ctrl);
                W_LED_OUT:  rd_mux = 32'(led_out);
                W_PRESCALE: rd_mux = 32'(prescale);
                W_STATUS:   rd_mux = 32'({blink_phase, pwm_cnt});
                default:    rd_mux = '0;
            endcase
            for (int i = 0; i < N_LED; i++) begin
                if (word == WW'(4 + i)) rd_mux = 32'(duty[i]);
            end
        end
    end
    assign bus.rd = rd_mux;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl        <= '0;
            led_out     <= '0;
            prescale    <= '0;
            presc_cnt   <= '0;
            pwm_cnt     <= '0;
            blink_phase <= 1'b0;
            led         <= '0;
            for (int i = 0; i < N_LED; i++) duty[i] <= '0;
        end else begin
            if (wr) begin
                case (word)
                    W_CTRL:     ctrl     <= bus.wd[2:0];
                    W_LED_OUT:  led_out  <= bus.wd[N_LED-1:0];
                    W_PRESCALE: prescale <= bus.wd[PRESCALE_W-1:0];
                    default:    ;
                endcase
                for (int i = 0; i < N_LED; i++) begin
                    if (word == WW'(4 + i)) duty[i] <= bus.wd[PWM_BITS:0];
                end
            end

            // A clearing store wins over a tick landing on the same edge
            if (clear) begin
                presc_cnt   <= '0;
                pwm_cnt     <= '0;
                blink_phase <= 1'b0;
            end else if (tick) begin
                presc_cnt <= '0;
                pwm_cnt   <= pwm_cnt + 1'b1;
                if (pwm_cnt == '1) blink_phase <= ~blink_phase;
            end else if (ctrl[0]) begin
                presc_cnt <= presc_cnt + 1'b1;
            end

            for (int i = 0; i < N_LED; i++) begin
                led[i] <= ctrl[0] && raw[i] && !(ctrl[2] && blink_phase);
            end
        end
    end
endmodule

// File: tb/tb_mmio_led_pwm.sv
// tb/tb_mmio_led_pwm.sv - directed-vector bench for mmio_led_pwm
module tb_mmio_led_pwm;
    localparam logic [31:0] CTRL   = 32'h1000;
    localparam logic [31:0] LEDO   = 32'h1004;
    localparam logic [31:0] PRESC  = 32'h1008;
    localparam logic [31:0] STATUS = 32'h100C;
    localparam logic [31:0] DUTY0  = 32'h1010;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] led;
    int vectors = 0;
    int miscompares = 0;

    mmio_led_pwm_if bus();

    mmio_led_pwm #(
        .BASE_ADDR(32'h0000_1000), .ADDR_W(8), .N_LED(8), .PWM_BITS(4), .PRESCALE_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .led(led)
    );

    always #5 clk = ~clk;

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.we = 1'b1; bus.a = addr; bus.wd = data;
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data);
        bus.a = addr;
        #1;
        data = bus.rd;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (led !== 8'h00) begin
            miscompares++; $display("FAIL reset_led: got %h want 00", led);
        end
        bus_rd(STATUS, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++; $display("FAIL reset_status: got %h want 0", d);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_static;
        bus_wr(CTRL, 32'h1);
        bus_wr(LEDO, 32'hA5);
        vectors++;
        if (led !== 8'h00) begin
            miscompares++; $display("FAIL static_latency: got %h want 00", led);
        end
        @(negedge clk);
        vectors++;
        if (led !== 8'hA5) begin
            miscompares++; $display("FAIL static_on: got %h want a5", led);
        end
        bus_wr(CTRL, 32'h0);
        @(negedge clk);
        vectors++;
        if (led !== 8'h00) begin
            miscompares++; $display("FAIL static_disable: got %h want 00", led);
        end
    endtask

    task automatic test_pwm;
        int hi0, hi1, hi2;
        hi0 = 0; hi1 = 0; hi2 = 0;
        bus_wr(PRESC, 32'h0);
        bus_wr(DUTY0, 32'd4);
        bus_wr(DUTY0 + 4, 32'd0);
        bus_wr(DUTY0 + 8, 32'd16);
        bus_wr(CTRL, 32'h3);
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            hi0 += int'(led[0]); hi1 += int'(led[1]); hi2 += int'(led[2]);
        end
        vectors++;
        if (hi0 != 4) begin
            miscompares++; $display("FAIL pwm_duty4: high %0d cycles want 4", hi0);
        end
        vectors++;
        if (hi1 != 0) begin
            miscompares++; $display("FAIL pwm_duty0: high %0d cycles want 0", hi1);
        end
        vectors++;
        if (hi2 != 16) begin
            miscompares++; $display("FAIL pwm_duty16: high %0d cycles want 16", hi2);
        end
    endtask

    task automatic test_prescale;
        logic [31:0] d;
        logic [3:0]  prev;
        int hi, changes, last, bad_gap;
        hi = 0; changes = 0; last = -1; bad_gap = 0;
        bus_wr(PRESC, 32'd2);
        bus_wr(DUTY0, 32'd8);
        bus_rd(STATUS, d);
        prev = d[3:0];
        for (int j = 0; j < 48; j++) begin
            @(negedge clk);
            hi += int'(led[0]);
            bus_rd(STATUS, d);
            if (d[3:0] != prev) begin
                changes++;
                if (last >= 0 && j - last != 3) bad_gap++;
                last = j;
            end
            prev = d[3:0];
        end
        vectors++;
        if (hi != 24) begin
            miscompares++; $display("FAIL presc_duty: high %0d cycles want 24", hi);
        end
        vectors++;
        if (changes != 16) begin
            miscompares++; $display("FAIL presc_steps: %0d steps want 16", changes);
        end
        vectors++;
        if (bad_gap != 0) begin
            miscompares++; $display("FAIL presc_gap: %0d gaps not 3 want 0", bad_gap);
        end
    endtask

    task automatic test_blink;
        logic [31:0] d;
        int bad_led, bad_phase;
        logic [7:0] exp_led;
        logic       exp_phase;
        bad_led = 0; bad_phase = 0;
        bus_wr(CTRL, 32'h0);
        bus_wr(LEDO, 32'hFF);
        bus_wr(PRESC, 32'h0);
        bus_wr(CTRL, 32'h5);
        for (int j = 1; j <= 48; j++) begin
            @(negedge clk);
            exp_led   = (((j - 1) / 16) % 2 == 0) ? 8'hFF : 8'h00;
            exp_phase = ((j / 16) % 2) == 1;
            bus_rd(STATUS, d);
            if (led !== exp_led) begin
                if (bad_led == 0) $display("cycle %0d led %h expected %h", j, led, exp_led);
                bad_led++;
            end
            if (d[4] !== exp_phase) bad_phase++;
        end
        vectors++;
        if (bad_led != 0) begin
            miscompares++; $display("FAIL blink_led: %0d bad cycles want 0", bad_led);
        end
        vectors++;
        if (bad_phase != 0) begin
            miscompares++; $display("FAIL blink_phase: %0d bad cycles want 0", bad_phase);
        end
    endtask

    task automatic test_decode;
        logic [31:0] d;
        bus_wr(32'h1104, 32'h12);
        bus_rd(32'h1104, d);
        vectors++;
        if (bus.sel !== 1'b0 || d !== 32'h0) begin
            miscompares++; $display("FAIL decode_outside: sel %b rd %h want 0 0", bus.sel, d);
        end
        bus_rd(LEDO, d);
        vectors++;
        if (d !== 32'hFF) begin
            miscompares++; $display("FAIL decode_ledout: got %h want ff", d);
        end
        bus_wr(32'h1040, 32'hDEAD_BEEF);
        bus_rd(32'h1040, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++; $display("FAIL decode_unmapped: got %h want 0", d);
        end
        bus_rd(32'h1012, d);
        vectors++;
        if (d !== 32'd8) begin
            miscompares++; $display("FAIL decode_bytelane: got %h want 8", d);
        end
        bus_wr(DUTY0 + 4, 32'hFFFF_FFFF);
        bus_rd(DUTY0 + 4, d);
        vectors++;
        if (d !== 32'h1F) begin
            miscompares++; $display("FAIL decode_duty_width: got %h want 1f", d);
        end
        bus_rd(CTRL, d);
        vectors++;
        if (d !== 32'h5) begin
            miscompares++; $display("FAIL decode_ctrl: got %h want 5", d);
        end
    endtask

    task automatic test_clear_priority;
        logic [31:0] d;
        bus_wr(CTRL, 32'h0);
        bus_wr(CTRL, 32'h1);
        repeat (14) @(negedge clk);
        bus_rd(STATUS, d);
        vectors++;
        if (d !== 32'd14) begin
            miscompares++; $display("FAIL clear_pre: got %h want e", d);
        end
        bus_wr(PRESC, 32'h0);
        bus_rd(STATUS, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++; $display("FAIL clear_wrap: got %h want 0", d);
        end
        @(negedge clk);
        bus_rd(STATUS, d);
        vectors++;
        if (d !== 32'h1) begin
            miscompares++; $display("FAIL clear_resume: got %h want 1", d);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        bus_wr(LEDO, 32'h3C);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (led !== 8'h00) begin
            miscompares++; $display("FAIL midreset_led: got %h want 00", led);
        end
        bus_rd(STATUS, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++; $display("FAIL midreset_status: got %h want 0", d);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        bus_rd(STATUS, d);
        vectors++;
        if (d !== 32'h0 || led !== 8'h00) begin
            miscompares++; $display("FAIL midreset_idle: status %h led %h want 0 00", d, led);
        end
    endtask

    initial begin
        bus.we = 1'b0;
        bus.a  = 32'h0;
        bus.wd = 32'h0;
        test_reset;
        test_static;
        test_pwm;
        test_prescale;
        test_blink;
        test_decode;
        test_clear_priority;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mmio_led_pwm.md
Name: mmio_led_pwm

Overview:
Memory-mapped LED/GPIO peripheral on the core's data-memory port, in parallel with dmem. It replaces direct debug-register LED wiring: stores from software drive a parametrised number of LED channels. Each channel runs in static, per-channel PWM, or blink-gated mode. The top level muxes rd into the core's read-data path when sel is high.

Parameters:
BASE_ADDR, 32'h0000_1000, base of the register window; aligned to 2^ADDR_W.
ADDR_W, 8, log2 of the window size in bytes; requires 16+4*N_LED <= 2^ADDR_W.
N_LED, 8, number of LED channels, 1..32.
PWM_BITS, 8, PWM counter width, 2..16.
PRESCALE_W, 16, prescaler width.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-high
we  input  1  store strobe from core (MemWrite)
a  input  32  byte address from core (ALUResult)
wd  input  32  store data
rd  output  32  load data, combinational
sel  output  1  a lies inside this block's window
led  output  N_LED  registered LED drive

Behaviour:
- Reset: one clock, asynchronous and active-high. While reset is high, all registers, counters, blink_phase and led are 0. rd and sel are combinational, so reset does not force them.
- Decode: sel = (a[31:ADDR_W] == BASE_ADDR[31:ADDR_W]); off = a[ADDR_W-1:0] with a[1:0] ignored. Writes are accepted at posedge clk when we && sel.
- Register map:
  - 0x00 CTRL, RW[2:0]: bit0 EN, bit1 MODE (0 = static, 1 = pwm), bit2 BLINK.
  - 0x04 LED_OUT, RW[N_LED-1:0].
  - 0x08 PRESCALE, RW[PRESCALE_W-1:0].
  - 0x0C STATUS, RO: {blink_phase at bit PWM_BITS, pwm_cnt[PWM_BITS-1:0]}.
  - 0x10+4*i DUTY[i], RW[PWM_BITS:0], for i < N_LED.
- Reads: unimplemented bits read 0. Unmapped offsets read 0, and writes to them are ignored. rd = 0 when sel = 0.
- Prescaler: presc_cnt counts 0..PRESCALE. tick = EN && (presc_cnt == PRESCALE); on tick, presc_cnt returns to 0. PRESCALE = 0 gives a tick every cycle.
- PWM counter: pwm_cnt increments on tick and wraps from 2^PWM_BITS-1 to 0. On each wrap, blink_phase toggles.
- Counter clears: a write to PRESCALE, or to CTRL with EN = 0, clears presc_cnt, pwm_cnt and blink_phase in that cycle. This clear overrides a tick in the same cycle.
- LED function, per channel i:
  - raw[i] = MODE ? (pwm_cnt < DUTY[i]) : LED_OUT[i]
  - led[i] <= EN && raw[i] && !(BLINK && blink_phase)
- Duty boundaries: DUTY = 0 is always off. DUTY >= 2^PWM_BITS is always on.
- Latency: led reflects a register write or counter value one clock later. Example: a write to LED_OUT at edge k is visible on led after edge k+1.
- Simultaneous events: a write updates its register at the same edge led samples the old value. No read side effects.
- Reset mid-PWM: all state returns to 0 immediately and asynchronously; after release, counting restarts only once EN is written again.

Test Plan:
- Reset/static: assert reset mid-run -> led = 0, STATUS reads 0. Write CTRL = 1, LED_OUT = 0xA5 -> led = 0xA5 two edges after the LED_OUT store. Write CTRL = 0 -> led = 0.
- PWM (PWM_BITS = 4, PRESCALE = 0): CTRL = 3, DUTY[0] = 4, DUTY[1] = 0, DUTY[2] = 16 -> per 16-cycle period, led[0] high exactly 4 cycles, led[1] always 0, led[2] always 1.
- Prescaler: PRESCALE = 2, DUTY[0] = 8, PWM_BITS = 4 -> period 48 cycles with led[0] high 24. STATUS pwm_cnt advances every 3rd cycle.
- Blink: CTRL = 5, LED_OUT = 0xFF, PWM_BITS = 4, PRESCALE = 0 -> led alternates 16 cycles 0xFF, 16 cycles 0x00. STATUS bit4 toggles accordingly.
- Decode: store to BASE+0x100 (outside window) -> no register change, sel = 0, rd = 0. Store to BASE+0x40 with N_LED = 8 (unmapped) -> ignored, reads 0. Load BASE+0x12 -> returns DUTY[0] (a[1:0] ignored).
- Clear priority: write PRESCALE on the cycle pwm_cnt wraps -> pwm_cnt = 0 and blink_phase unchanged from 0 on the next cycle.
